// File: rtl/sha_alarm_pkg.sv
// sha_alarm_pkg: shared source indices, buzzer cadences and FSM states for the alarm arbiter
package sha_alarm_pkg;

    localparam int N_SRC = 5;

    localparam logic [2:0] SRC_FIRE   = 3'd0;
    localparam logic [2:0] SRC_DOOR   = 3'd1;
    localparam logic [2:0] SRC_WIN    = 3'd2;
    localparam logic [2:0] SRC_GARAGE = 3'd3;
    localparam logic [2:0] SRC_LOCK   = 3'd4;
    localparam logic [2:0] SRC_NONE   = 3'd7;

    // One 8-slot cadence per source, played MSB first; entry i belongs to source i.
    localparam logic [N_SRC-1:0][7:0] PATTERN = {8'h80, 8'hF0, 8'hAA, 8'hCC, 8'hFF};

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

    // Lowest set index wins (fire outranks everything); SRC_NONE when nothing is pending.
    function automatic logic [2:0] first_set(input logic [N_SRC-1:0] p);
        first_set = SRC_NONE;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (p[i]) first_set = 3'(i);
    endfunction

endpackage

// File: rtl/sha_slot_timer.sv
// sha_slot_timer: divides the clock into pattern slots and counts slots within an 8-slot pattern
module sha_slot_timer #(
    parameter int TICK_DIV = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] slot,
    output logic       slot_end,
    output logic       end_of_pattern
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick;

    assign slot_end       = enable && tick == TW'(TICK_DIV - 1);
    assign end_of_pattern = slot_end && slot == 3'd7;

    // Tick counter wraps every TICK_DIV cycles and advances the slot; clear restarts slot 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= '0;
            slot <= '0;
        end else if (clear) begin
            tick <= '0;
            slot <= '0;
        end else if (slot_end) begin
            tick <= '0;
            slot <= slot + 3'd1;
        end else if (enable) begin
            tick <= tick + TW'(1);
        end
    end

endmodule

// File: rtl/sha_alarm_arbiter.sv
// sha_alarm_arbiter: latches alarm events and shares the buzzer by fixed priority with fire preemption
module sha_alarm_arbiter #(
    parameter int TICK_DIV = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       security_active,
    input  logic       silence,
    output logic       buzzer,
    output logic       busy,
    output logic [2:0] grant_id,
    output logic [4:0] pending
);

    import sha_alarm_pkg::*;

    state_t     state;
    logic [4:0] req_q;
    logic [4:0] accepted;
    logic [4:0] take;
    logic [4:0] pending_n;
    logic [2:0] win;
    logic [2:0] slot;
    logic [7:0] pat;
    logic       slot_end;
    logic       pattern_end;
    logic       sil_ok;
    logic       sec_drop;
    logic       preempt;
    logic       pat_end;
    logic       gap_done;
    logic       timer_clear;

    // Intrusion sources only latch while armed; fire and keypad lockout always latch.
    assign accepted = (req & ~req_q) & (security_active ? 5'b11111 : 5'b10001);
    assign win      = first_set(pending);
    assign busy     = state != ST_IDLE;
    // Fire cannot be acknowledged while smoke is still reported.
    assign sil_ok   = busy && silence && !(grant_id == SRC_FIRE && req[0]);
    assign sec_drop = busy && !security_active && grant_id >= SRC_DOOR && grant_id <= SRC_GARAGE;
    assign preempt  = busy && pending[SRC_FIRE] && grant_id != SRC_FIRE;
    assign pat_end  = state == ST_PLAY && pattern_end;
    assign gap_done = state == ST_GAP && slot_end;
    // A same-winner restart wraps naturally; every other transition restarts at slot 0, tick 0.
    assign timer_clear = !busy || sil_ok || sec_drop || preempt || gap_done || (pat_end && win != grant_id);
    assign pat = grant_id < 3'(N_SRC) ? PATTERN[grant_id] : 8'h00;

    sha_slot_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk            (clk),
        .reset          (reset),
        .clear          (timer_clear),
        .enable         (busy),
        .slot           (slot),
        .slot_end       (slot_end),
        .end_of_pattern (pattern_end)
    );

    // Granting consumes the winner's event; new events then latch, and silence overrides both.
    always_comb begin
        take = (sil_ok || sec_drop) ? 5'b0 : preempt ? 5'b00001 : (!busy || pat_end) ? 5'b1 << win : 5'b0;
        pending_n = ((pending & ~take) | accepted) & ~(sil_ok ? 5'b1 << grant_id : 5'b0);
        if (!security_active) pending_n[3:1] = 3'b0;
    end

    // Arbitration FSM with registered buzzer, grant and pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant_id <= SRC_NONE;
            pending  <= '0;
            req_q    <= '0;
            buzzer   <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= pending_n;
            buzzer  <= state == ST_PLAY && pat[3'd7 - slot];
            if (sil_ok || sec_drop) begin
                state    <= ST_IDLE;
                grant_id <= SRC_NONE;
            end else if (preempt) begin
                state    <= ST_PLAY;
                grant_id <= SRC_FIRE;
            end else if (state == ST_IDLE) begin
                if (win != SRC_NONE) begin
                    state    <= ST_PLAY;
                    grant_id <= win;
                end
            end else if (gap_done) begin
                state <= ST_PLAY;
            end else if (pat_end && win != grant_id) begin
                state    <= win == SRC_NONE ? ST_IDLE : ST_GAP;
                grant_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_sha_alarm_arbiter.sv
// tb_sha_alarm_arbiter: vector table, directed corner sequences and a random run against a behavioural model
module tb_sha_alarm_arbiter;

    localparam int TD = 4;
    localparam bit [7:0] PAT [5] = '{8'hFF, 8'hCC, 8'hAA, 8'hF0, 8'h80};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req = '0;
    logic       security_active = 1'b1;
    logic       silence = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [2:0] grant_id;
    logic [4:0] pending;

    int n_chk = 0;
    int n_pass = 0;

    sha_alarm_arbiter #(.TICK_DIV(TD)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .security_active (security_active),
        .silence         (silence),
        .buzzer          (buzzer),
        .busy            (busy),
        .grant_id        (grant_id),
        .pending         (pending)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 playing, 2 gap; pos counts cycles since the pattern (or gap) began
    typedef struct {
        bit [4:0] pend;
        int       mode;
        int       grant;
        int       pos;
        bit       buz;
        bit [4:0] reqq;
    } m_t;

    m_t m;

    function automatic int lowest(bit [4:0] p);
        for (int i = 0; i < 5; i++)
            if (p[i]) return i;
        return 5;
    endfunction

    function automatic m_t step(m_t s, logic [4:0] r, logic sec, logic sil);
        m_t n;
        bit [4:0] ev, take, kill;
        int w;
        n = s;
        take = 0;
        kill = 0;
        ev = r & ~s.reqq;
        if (!sec) ev = ev & 5'b10001;
        w = lowest(s.pend);
        n.reqq = r;
        n.buz = 0;
        if (s.mode == 1) n.buz = PAT[s.grant][7 - s.pos / TD];
        n.pos = s.pos + 1;
        if (s.mode != 0 && sil && !(s.grant == 0 && r[0])) begin
            kill[s.grant] = 1;
            n.mode = 0;
        end else if (s.mode != 0 && !sec && s.grant >= 1 && s.grant <= 3) begin
            n.mode = 0;
        end else if (s.mode != 0 && s.pend[0] && s.grant != 0) begin
            n.mode = 1; n.grant = 0; n.pos = 0; take[0] = 1;
        end else if (s.mode == 0 && w < 5) begin
            n.mode = 1; n.grant = w; n.pos = 0; take[w] = 1;
        end else if (s.mode == 2 && s.pos == TD - 1) begin
            n.mode = 1; n.pos = 0;
        end else if (s.mode == 1 && s.pos == 8 * TD - 1) begin
            n.pos = 0;
            if (w == 5) n.mode = 0;
            else begin
                take[w] = 1;
                if (w != s.grant) begin
                    n.mode = 2;
                    n.grant = w;
                end
            end
        end
        if (n.mode == 0) begin
            n.grant = 7;
            n.pos = 0;
        end
        n.pend = ((s.pend & ~take) | ev) & ~kill;
        if (!sec) n.pend[3:1] = 0;
        return n;
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) m <= '{5'd0, 0, 7, 0, 1'b0, 5'd0};
        else m <= step(m, req, security_active, silence);

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        silence = 1'b0;
        security_active = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic [4:0] req;
        logic       sec;
        logic [4:0] p1;
        logic [2:0] g;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [67:0] seq;
        logic        all_one;
        vt[0] = '{5'b00010, 1'b1, 5'b00010, 3'd1};
        vt[1] = '{5'b00010, 1'b0, 5'b00000, 3'd7};
        vt[2] = '{5'b01110, 1'b0, 5'b00000, 3'd7};
        vt[3] = '{5'b10000, 1'b0, 5'b10000, 3'd4};
        vt[4] = '{5'b01100, 1'b1, 5'b01100, 3'd2};
        vt[5] = '{5'b11111, 1'b1, 5'b11111, 3'd0};
        vt[6] = '{5'b11000, 1'b1, 5'b11000, 3'd3};
        vt[7] = '{5'b11111, 1'b0, 5'b10001, 3'd0};

        do_reset();
        chk("reset_state", {buzzer, busy, grant_id, pending}, {1'b0, 1'b0, 3'd7, 5'd0});

        // event latching and priority: pending one edge after the request, grant the edge after
        for (int i = 0; i < 8; i++) begin
            do_reset();
            security_active = vt[i].sec;
            req = vt[i].req;
            cyc();
            chk($sformatf("vec%0d_pend", i), pending, vt[i].p1);
            req = '0;
            cyc();
            chk($sformatf("vec%0d_grant", i), grant_id, vt[i].g);
        end

        // door cadence, then silence of a re-latched door
        do_reset();
        req = 5'b00010;
        cyc();
        chk("door_pend", pending, 5'b00010);
        req = '0;
        cyc();
        chk("door_grant", {busy, grant_id}, {1'b1, 3'd1});
        seq = '0;
        for (int k = 0; k < 32; k++) begin
            cyc();
            seq = {seq[66:0], buzzer};
        end
        chk("door_cadence", seq[31:0], 32'hFF00_FF00);
        cyc();
        chk("door_done", {busy, grant_id}, {1'b0, 3'd7});
        req = 5'b00010;
        cyc();
        req = '0;
        cyc();
        cyc();
        req = 5'b00010;
        cyc();
        req = '0;
        chk("door_relatch", pending, 5'b00010);
        cyc();
        cyc();
        silence = 1'b1;
        cyc();
        silence = 1'b0;
        chk("door_silenced", {busy, grant_id, pending}, {1'b0, 3'd7, 5'd0});
        cyc();
        chk("door_sil_buzzer", buzzer, 1'b0);

        // fire preempts door mid slot 3 and cannot be silenced while smoke persists
        do_reset();
        req = 5'b00010;
        cyc();
        req = '0;
        repeat (14) cyc();
        req = 5'b00001;
        cyc();
        chk("fire_pend", {pending, grant_id}, {5'b00001, 3'd1});
        cyc();
        chk("fire_grant", grant_id, 3'd0);
        all_one = 1'b1;
        for (int k = 0; k < 13; k++) begin
            cyc();
            all_one &= buzzer;
        end
        chk("fire_continuous", all_one, 1'b1);
        silence = 1'b1;
        cyc();
        silence = 1'b0;
        chk("fire_sil_ignored", {busy, grant_id, buzzer}, {1'b1, 3'd0, 1'b1});
        req = '0;
        cyc();
        silence = 1'b1;
        cyc();
        silence = 1'b0;
        chk("fire_silenced", {busy, grant_id}, {1'b0, 3'd7});
        cyc();
        chk("fire_sil_buzzer", buzzer, 1'b0);

        // door then garage with a one-slot gap between them
        do_reset();
        req = 5'b01010;
        cyc();
        chk("dg_pend", pending, 5'b01010);
        req = '0;
        cyc();
        chk("dg_grant", grant_id, 3'd1);
        seq = '0;
        for (int k = 0; k < 68; k++) begin
            cyc();
            if (k == 32) chk("dg_gap_grant", {busy, grant_id}, {1'b1, 3'd3});
            seq = {seq[66:0], buzzer};
        end
        chk("dg_door", seq[67:36], 32'hFF00_FF00);
        chk("dg_gap_garage", seq[35:0], 36'h0_FFFF_0000);
        cyc();
        chk("dg_idle", grant_id, 3'd7);

        // disarmed: intrusion ignored, lockout still sounds
        do_reset();
        security_active = 1'b0;
        req = 5'b01110;
        cyc();
        req = '0;
        cyc();
        cyc();
        chk("disarmed_quiet", {pending, busy, buzzer}, {5'd0, 1'b0, 1'b0});
        req = 5'b10000;
        cyc();
        req = '0;
        cyc();
        chk("lock_grant", grant_id, 3'd4);
        seq = '0;
        for (int k = 0; k < 32; k++) begin
            cyc();
            seq = {seq[66:0], buzzer};
        end
        chk("lock_cadence", seq[31:0], 32'hF000_0000);

        // disarm while door plays with a fresh door event latched
        do_reset();
        req = 5'b00010;
        cyc();
        req = '0;
        cyc();
        cyc();
        req = 5'b00010;
        cyc();
        req = '0;
        chk("drop_relatch", pending, 5'b00010);
        cyc();
        cyc();
        security_active = 1'b0;
        cyc();
        chk("drop_idle", {busy, grant_id, pending}, {1'b0, 3'd7, 5'd0});
        cyc();
        chk("drop_buzzer", buzzer, 1'b0);

        // asynchronous reset mid-pattern
        do_reset();
        req = 5'b10010;
        cyc();
        req = '0;
        repeat (4) cyc();
        chk("pre_reset", {buzzer, grant_id, pending}, {1'b1, 3'd1, 5'b10000});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {buzzer, busy, grant_id, pending}, {1'b0, 1'b0, 3'd7, 5'd0});

        // silence and a new window edge on the same cycle
        do_reset();
        req = 5'b00100;
        cyc();
        req = '0;
        cyc();
        chk("win_grant", grant_id, 3'd2);
        cyc();
        cyc();
        req = 5'b00100;
        silence = 1'b1;
        cyc();
        silence = 1'b0;
        chk("win_sil_event", {pending, grant_id}, {5'd0, 3'd7});
        cyc();
        chk("win_no_relatch", {pending, busy}, {5'd0, 1'b0});
        req = '0;

        // randomized run against the behavioural model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            chk("rand", {buzzer, busy, grant_id, pending}, {m.buz, m.mode != 0, m.grant[2:0], m.pend});
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, b == 0 ? 39 : 15) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 199) == 0) security_active = ~security_active;
            silence = $urandom_range(0, 29) == 0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
